buzzer_tone_gen: RTL and testbench
==================================

Name: buzzer_tone_gen

Overview:
- Downstream consumer of the alarm sequencer's 13-bit one-hot `beat` note code.
- Converts the current note into a 50%-duty square wave that drives the piezo buzzer at that note's pitch.
- Runs on the single system clock; the sequencer's slow state rate is irrelevant here, and each note is held for as long as `beat` is stable.
- Gives the alarm its audible output; `light` is handled elsewhere.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz; constraint CLK_HZ >= 4*523.
- CNT_W, 20, width of the half-period counter; must hold CLK_HZ/524.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- beat  input  13  one-hot note code from the alarm sequencer; all-zero means rest.
- enable  input  1  1 = sound allowed; 0 = mute with tone held low.
- tone  output  1  square wave to the buzzer driver.
- note_valid  output  1  registered; 1 when the accepted code is exactly one-hot.
- note_idx  output  4  registered index 0..12 of the accepted note; 0 when not valid.

Behaviour:
- Reset values (asynchronous, immediate): beat_q=0, note_valid=0, note_idx=0, cnt=0, tone=0.
- Input stage: beat_q <= beat every clock.
- Decode (combinational from beat_q):
  - Exactly one bit i set -> dvalid=1, didx=i.
  - Zero bits or more than one bit set -> dvalid=0, didx=0.
- Note map, bit i -> frequency f(i) Hz: 0:262 1:277 2:294 3:311 4:330 5:349 6:370 7:392 8:415 9:440 10:466 11:494 12:523.
  - half(i) = CLK_HZ/(2*f(i)), integer division, truncated.
  - Computed at elaboration as constants.
- Note change (dvalid!=note_valid or didx!=note_idx) in a cycle:
  - note_valid<=dvalid, note_idx<=didx.
  - cnt<=0, tone<=0 (phase restart).
  - Takes priority over all counting.
- Otherwise, if note_valid=0 or enable=0: cnt<=0, tone<=0.
- Otherwise, if cnt==half(note_idx)-1: cnt<=0, tone<=~tone.
- Otherwise: cnt<=cnt+1.
- Latency:
  - beat change at edge N is registered in beat_q at edge N.
  - note_valid/note_idx update at edge N+1.
  - First tone rise at edge N+1+half.
  - Tone period thereafter is 2*half clocks.
- Steady `beat` gives a continuous square wave with no glitches; high and low phases are each exactly half clocks.
- Same note repeated across sequencer states (e.g. 0x1000 followed by 0x1000) is not a change: no phase restart.
- Rest or invalid code: tone low within 2 cycles, counter cleared.
- enable falling: tone forced low on the next edge.
- enable rising: counting restarts from cnt=0, tone low; first rise after half clocks.
- Reset asserted mid-tone: all outputs clear immediately. After release, a stable beat produces its first rise at edge 2+half after the first clock.
- Counter never exceeds half-1; no wrap beyond CNT_W.
- tone is a direct register output.

Test Plan:
1. CLK_HZ=5240, enable=1, beat=13'h0001 held -> note_valid=1 and note_idx=0 one cycle after beat_q. tone rises 10 clocks later, then toggles every 10 clocks (period 20).
2. CLK_HZ=5240, beat switches 13'h0001 -> 13'h1000 mid high phase -> tone=0 on the update edge, note_idx=12, then toggles every 5 clocks (5240/1046=5).
3. beat=13'h0000, then beat=13'h1001 (multi-hot) -> note_valid=0, note_idx=0, tone held 0, cnt stays 0.
4. Note 9 playing (half=5240/880=5); deassert enable for 7 clocks, then reassert -> tone low the edge after deassert, note_valid stays 1. After reassert, tone rises 5 clocks later.
5. beat rewritten with the identical value 13'h0400 each cycle -> waveform is unaffected, no phase restart, period stays 2*half(10)=2*5=10 clocks.
6. Pulse reset while tone=1 -> tone, note_valid, note_idx and cnt read 0 before the next clock edge. After release, tone resumes from phase 0 with a stable beat.

Source files
------------

// File: rtl/buzzer_tone_gen.sv
// Piezo tone generator: turns the sequencer's one-hot note code into a
// 50%-duty square wave at that note's pitch, with mute and rest handling.
module buzzer_tone_gen #(
    parameter int CLK_HZ = 50000000,
    parameter int CNT_W  = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:0] beat,
    input  logic        enable,
    output logic        tone,
    output logic        note_valid,
    output logic [3:0]  note_idx
);

    typedef logic [CNT_W-1:0] cnt_t;

    // Terminal count (half period minus one) for note i, folded at elaboration.
    function automatic cnt_t half_lim(input int i);
        int f;
        case (i)
            0:       f = 262;
            1:       f = 277;
            2:       f = 294;
            3:       f = 311;
            4:       f = 330;
            5:       f = 349;
            6:       f = 370;
            7:       f = 392;
            8:       f = 415;
            9:       f = 440;
            10:      f = 466;
            11:      f = 494;
            default: f = 523;
        endcase
        return cnt_t'(CLK_HZ / (2 * f) - 1);
    endfunction

    logic [15:0][CNT_W-1:0] lim;

    for (genvar g = 0; g < 16; g++) begin : g_lim
        assign lim[g] = half_lim(g);
    end

    logic [12:0] beat_q;
    cnt_t        cnt;
    logic        dvalid;
    logic [3:0]  didx;
    logic [3:0]  ones;
    logic [3:0]  last_idx;
    logic        note_change;

    always_comb begin
        ones     = 4'd0;
        last_idx = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (beat_q[i]) begin
                ones     = ones + 4'd1;
                last_idx = 4'(i);
            end
        end
        dvalid = (ones == 4'd1);
        didx   = dvalid ? last_idx : 4'd0;
    end

    assign note_change = (dvalid != note_valid) || (didx != note_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_q     <= '0;
            note_valid <= 1'b0;
            note_idx   <= 4'd0;
            cnt        <= '0;
            tone       <= 1'b0;
        end else begin
            beat_q <= beat;
            // A new note always restarts the phase, even if muted.
            if (note_change) begin
                note_valid <= dvalid;
                note_idx   <= didx;
                cnt        <= '0;
                tone       <= 1'b0;
            end else if (!note_valid || !enable) begin
                cnt  <= '0;
                tone <= 1'b0;
            end else if (cnt == lim[note_idx]) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Scenario bench for buzzer_tone_gen at CLK_HZ=5240: expected waveform pushed
// to a scoreboard queue per edge, popped and compared after each edge.
module tb_buzzer_tone_gen;

    localparam int CLK_HZ = 5240;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] beat = '0;
    logic        enable = 1'b1;
    logic        tone;
    logic        note_valid;
    logic [3:0]  note_idx;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       tone;
        logic       nv;
        logic [3:0] idx;
    } obs_t;

    obs_t exp_q[$];
    int   freq[13] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494, 523};

    buzzer_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(20)) dut (
        .clock(clock), .reset(reset), .beat(beat), .enable(enable),
        .tone(tone), .note_valid(note_valid), .note_idx(note_idx)
    );

    always #5 clock = ~clock;

    function automatic int half_of(input int i);
        return CLK_HZ / (2 * freq[i]);
    endfunction

    // Waveform after a phase-restart point u (cnt=0, tone=0 registered at edge u).
    function automatic obs_t model(input int k, input int u, input int h,
                                   input logic [3:0] idx);
        obs_t o;
        o.nv   = 1'b1;
        o.idx  = idx;
        o.tone = (k >= u) ? (((k - u) / h) % 2 == 1) : 1'b0;
        return o;
    endfunction

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1; beat = '0; enable = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        #1;
        got = {tone, note_valid, note_idx};
        checks++;
        if (got !== 6'b0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=00", got);
        end
        checks++;
        if (dut.cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_steady_note0();
        obs_t e, got;
        int h = half_of(0);
        do_reset();
        beat = 13'h0001;
        for (int k = 1; k <= 45; k++) begin
            exp_q.push_back(k == 1 ? obs_t'(6'b0) : model(k, 2, h, 4'd0));
            @(posedge clock); #1;
            e = exp_q.pop_front(); got = {tone, note_valid, note_idx};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL steady_note0 edge=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, got;
        int h0 = half_of(0);
        int h12 = half_of(12);
        do_reset();
        beat = 13'h0001;
        for (int k = 1; k <= 36; k++) begin
            if (k == 15) beat = 13'h1000;  // lands mid high phase of note 0
            if (k == 1)       exp_q.push_back(6'b0);
            else if (k <= 15) exp_q.push_back(model(k, 2, h0, 4'd0));
            else              exp_q.push_back(model(k, 16, h12, 4'd12));
            @(posedge clock); #1;
            e = exp_q.pop_front(); got = {tone, note_valid, note_idx};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL note_switch edge=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_rest_invalid();
        obs_t e, got;
        int h = half_of(0);
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            beat = (k <= 4) ? 13'h0000 : 13'h1001;
            exp_q.push_back(6'b0);
            @(posedge clock); #1;
            e = exp_q.pop_front(); got = {tone, note_valid, note_idx};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL rest_invalid edge=%0d got=%h exp=%h", k, got, e);
            end
            checks++;
            if (dut.cnt !== '0) begin
                errors++; $display("FAIL rest_cnt edge=%0d got=%0d exp=0", k, dut.cnt);
            end
        end
        do_reset();
        beat = 13'h0001;
        for (int k = 1; k <= 18; k++) begin
            if (k == 15) beat = 13'h0000;
            if (k == 1 || k >= 16) exp_q.push_back(6'b0);
            else                   exp_q.push_back(model(k, 2, h, 4'd0));
            @(posedge clock); #1;
            e = exp_q.pop_front(); got = {tone, note_valid, note_idx};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL rest_after_tone edge=%0d got=%h exp=%h", k, got, e);
            end
        end
        checks++;
        if (dut.cnt !== '0) begin
            errors++; $display("FAIL rest_after_cnt got=%0d exp=0", dut.cnt);
        end
    endtask

    task automatic test_enable();
        obs_t e, got;
        int h = half_of(9);
        do_reset();
        beat = 13'h0200;
        for (int k = 1; k <= 30; k++) begin
            if (k == 9)  enable = 1'b0;
            if (k == 16) enable = 1'b1;
            if (k == 1)                exp_q.push_back(6'b0);
            else if (k <= 8)           exp_q.push_back(model(k, 2, h, 4'd9));
            else if (k <= 15)          exp_q.push_back({1'b0, 1'b1, 4'd9});
            else                       exp_q.push_back(model(k, 15, h, 4'd9));
            @(posedge clock); #1;
            e = exp_q.pop_front(); got = {tone, note_valid, note_idx};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL enable edge=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_same_note_repeat();
        obs_t e, got;
        int h = half_of(10);
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            beat = 13'h0400;
            exp_q.push_back(k == 1 ? obs_t'(6'b0) : model(k, 2, h, 4'd10));
            @(posedge clock); #1;
            e = exp_q.pop_front(); got = {tone, note_valid, note_idx};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL same_note edge=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_tone();
        obs_t e, got;
        int h = half_of(0);
        do_reset();
        beat = 13'h0001;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clock); #1;
        end
        checks++;
        if (tone !== 1'b1) begin
            errors++; $display("FAIL pre_reset_tone got=%b exp=1", tone);
        end
        reset = 1'b1;
        #1;
        got = {tone, note_valid, note_idx};
        checks++;
        if (got !== 6'b0) begin
            errors++; $display("FAIL mid_reset_outputs got=%h exp=00", got);
        end
        checks++;
        if (dut.cnt !== '0) begin
            errors++; $display("FAIL mid_reset_cnt got=%0d exp=0", dut.cnt);
        end
        #1 reset = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            exp_q.push_back(k == 1 ? obs_t'(6'b0) : model(k, 2, h, 4'd0));
            @(posedge clock); #1;
            e = exp_q.pop_front(); got = {tone, note_valid, note_idx};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL after_reset edge=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady_note0();
        test_back_to_back();
        test_rest_invalid();
        test_enable();
        test_same_note_repeat();
        test_reset_mid_tone();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
